fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and drives a single-outstanding-request instruction-memory port.
- Holds the IF/ID pipeline register (instr, pc, pc+4, valid) that feeds decode (fs_o_instr → decode instr input, fs_o_ce → decode ce input).
- Handles decode stalls through a one-entry skid buffer, and handles branch/jal/jr redirects and flushes from later stages.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_if_id_reg.sv | 93 +++++++++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, reset constants and FSM encoding for the fetch stage
package fetch_stage_pkg;

  localparam int          FS_PC_WIDTH  = 32;
  localparam int          FS_IWIDTH    = 32;
  localparam logic [31:0] FS_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] FS_INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_HOLD  = 2'd1,
    FS_DROP  = 2'd2
  } fs_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with a one-entry skid buffer
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int                PC_WIDTH = FS_PC_WIDTH,
  parameter int                IWIDTH   = FS_IWIDTH,
  parameter logic [IWIDTH-1:0] NOP      = IWIDTH'(FS_INSTR_NOP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                load_valid,
  input  logic                push_valid,
  input  logic [IWIDTH-1:0]   in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                slot_free,
  output logic                ce,
  output logic [IWIDTH-1:0]   instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4
);

  logic                ce_q, ce_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc4_q, pc4_d;
  logic                skid_valid_q, skid_valid_d;
  logic [IWIDTH-1:0]   skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;

  assign slot_free = !stall || !ce_q;

  always_comb begin
    ce_d         = ce_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      ce_d         = 1'b0;
      skid_valid_d = 1'b0;
    end else if (slot_free) begin
      // The skid always holds the older instruction, so it drains first.
      if (skid_valid_q) begin
        ce_d         = 1'b1;
        instr_d      = skid_instr_q;
        pc_d         = skid_pc_q;
        pc4_d        = skid_pc_q + PC_WIDTH'(4);
        skid_valid_d = 1'b0;
      end else if (load_valid) begin
        ce_d    = 1'b1;
        instr_d = in_instr;
        pc_d    = in_pc;
        pc4_d   = in_pc + PC_WIDTH'(4);
      end else begin
        ce_d = 1'b0;
      end
    end
    if (push_valid) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q         <= 1'b0;
      instr_q      <= NOP;
      pc_q         <= '0;
      pc4_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= '0;
    end else begin
      ce_q         <= ce_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign ce       = ce_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, single-outstanding imem port, redirect/stall handling
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                  PC_WIDTH = FS_PC_WIDTH,
  parameter int                  IWIDTH   = FS_IWIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(FS_RESET_PC)
) (
  input  logic                fs_clk,
  input  logic                fs_rst,
  input  logic                fs_i_stall,
  input  logic                fs_i_flush,
  input  logic                fs_i_redirect,
  input  logic [PC_WIDTH-1:0] fs_i_redirect_pc,
  output logic                fs_o_imem_req,
  output logic [PC_WIDTH-1:0] fs_o_imem_addr,
  input  logic                fs_i_imem_ack,
  input  logic [IWIDTH-1:0]   fs_i_imem_data,
  output logic [IWIDTH-1:0]   fs_o_instr,
  output logic [PC_WIDTH-1:0] fs_o_pc,
  output logic [PC_WIDTH-1:0] fs_o_pc_plus4,
  output logic                fs_o_ce
);

  fs_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] a_q, a_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [PC_WIDTH-1:0] redirect_tgt;
  logic                slot_free, load_valid, push_valid;

  assign redirect_tgt   = fs_i_redirect_pc & ~PC_WIDTH'(3);
  assign fs_o_imem_addr = a_q;
  assign fs_o_imem_req  = fs_rst && (state_q != FS_HOLD);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    tgt_d      = tgt_q;
    load_valid = 1'b0;
    push_valid = 1'b0;
    unique case (state_q)
      FS_FETCH: begin
        if (fs_i_imem_ack) begin
          if (fs_i_redirect) begin
            a_d = redirect_tgt;
          end else begin
            a_d = a_q + PC_WIDTH'(4);
            // A flush squashes IF/ID this edge, so a sequential response parks in the skid.
            if (slot_free && !fs_i_flush) begin
              load_valid = 1'b1;
            end else begin
              push_valid = 1'b1;
              state_d    = FS_HOLD;
            end
          end
        end else if (fs_i_redirect) begin
          tgt_d   = redirect_tgt;
          state_d = FS_DROP;
        end
      end
      FS_HOLD: begin
        if (fs_i_redirect) begin
          a_d     = redirect_tgt;
          state_d = FS_FETCH;
        end else if (fs_i_flush || slot_free) begin
          state_d = FS_FETCH;
        end
      end
      FS_DROP: begin
        if (fs_i_redirect) begin
          tgt_d = redirect_tgt;
        end
        if (fs_i_imem_ack) begin
          a_d     = fs_i_redirect ? redirect_tgt : tgt_q;
          state_d = FS_FETCH;
        end
      end
      default: state_d = FS_FETCH;
    endcase
  end

  always_ff @(posedge fs_clk or negedge fs_rst) begin
    if (!fs_rst) begin
      state_q <= FS_FETCH;
      a_q     <= RESET_PC;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      tgt_q   <= tgt_d;
    end
  end

  fetch_stage_if_id_reg #(
    .PC_WIDTH (PC_WIDTH),
    .IWIDTH   (IWIDTH)
  ) u_if_id (
    .clk        (fs_clk),
    .rst_n      (fs_rst),
    .stall      (fs_i_stall),
    .flush      (fs_i_flush || fs_i_redirect),
    .load_valid (load_valid),
    .push_valid (push_valid),
    .in_instr   (fs_i_imem_data),
    .in_pc      (a_q),
    .slot_free  (slot_free),
    .ce         (fs_o_ce),
    .instr      (fs_o_instr),
    .pc         (fs_o_pc),
    .pc_plus4   (fs_o_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench: directed vector table, reset/wrap sequences, random stream model
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic        ack;
  logic [31:0] imem_data;
  logic        fs_o_imem_req, fs_o_ce;
  logic [31:0] fs_o_imem_addr, fs_o_instr, fs_o_pc, fs_o_pc_plus4;

  fetch_stage dut (
    .fs_clk           (clk),
    .fs_rst           (rst_n),
    .fs_i_stall       (stall),
    .fs_i_flush       (flush),
    .fs_i_redirect    (redirect),
    .fs_i_redirect_pc (redirect_pc),
    .fs_o_imem_req    (fs_o_imem_req),
    .fs_o_imem_addr   (fs_o_imem_addr),
    .fs_i_imem_ack    (ack),
    .fs_i_imem_data   (imem_data),
    .fs_o_instr       (fs_o_instr),
    .fs_o_pc          (fs_o_pc),
    .fs_o_pc_plus4    (fs_o_pc_plus4),
    .fs_o_ce          (fs_o_ce)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        s, f, r;
    logic [31:0] rpc;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ce;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  int          n_cmp, n_err;
  int          age, lat;
  bit          rnd_lat;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[15:0], 16'hC3C3};
  endfunction

  function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                              input int l, input logic eq, input logic [31:0] ea,
                              input logic ec, input logic [31:0] ep);
    vec_t v;
    v.s = s; v.f = f; v.r = r; v.rpc = rpc; v.lat = l;
    v.e_req = eq; v.e_addr = ea; v.e_ce = ec; v.e_pc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: a request is answered once it has been pending for lat cycles.
  task automatic mem_eval();
    if (!(rst_n && fs_o_imem_req)) begin
      age = 0;
    end else if (!prev_req || prev_ack) begin
      age = 0;
      if (rnd_lat) lat = int'($urandom_range(1, 4));
    end else begin
      age++;
    end
  endtask

  task automatic drive_ack();
    ack       = rst_n && fs_o_imem_req && (age >= lat);
    imem_data = ack ? mem_word(fs_o_imem_addr) : 32'h0BAD_0BAD;
  endtask

  task automatic tick();
    prev_req  = fs_o_imem_req;
    prev_ack  = ack;
    prev_addr = fs_o_imem_addr;
    @(posedge clk);
    #1;
    mem_eval();
    drive_ack();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    mem_eval();
    drive_ack();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " req"}, {31'b0, fs_o_imem_req}, 32'd0);
    check({tag, " ce"}, {31'b0, fs_o_ce}, 32'd0);
    check({tag, " instr"}, fs_o_instr, 32'h0);
    check({tag, " pc"}, fs_o_pc, 32'h0);
    check({tag, " pc4"}, fs_o_pc_plus4, 32'h0);
    check({tag, " addr"}, fs_o_imem_addr, 32'h0);
  endtask

  logic [31:0] exp_pc;
  int          consumed, n;

  initial begin
    n_cmp = 0; n_err = 0; age = 0; lat = 1; rnd_lat = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ack = 1'b0; imem_data = '0;

    //  stall flush redir rpc          lat | req addr          ce pc
    vecs[0]  = mk(0, 0, 0, 32'h0,   1, 1, 32'h000, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 32'h0,   1, 1, 32'h000, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 32'h0,   1, 1, 32'h004, 1, 32'h000);
    vecs[3]  = mk(0, 0, 0, 32'h0,   1, 1, 32'h004, 0, 32'h0);
    vecs[4]  = mk(1, 0, 0, 32'h0,   1, 1, 32'h008, 1, 32'h004);
    vecs[5]  = mk(1, 0, 0, 32'h0,   1, 1, 32'h008, 1, 32'h004);
    vecs[6]  = mk(1, 0, 0, 32'h0,   1, 0, 32'h00C, 1, 32'h004);
    vecs[7]  = mk(0, 0, 0, 32'h0,   1, 0, 32'h00C, 1, 32'h004);
    vecs[8]  = mk(0, 0, 0, 32'h0,   1, 1, 32'h00C, 1, 32'h008);
    vecs[9]  = mk(0, 0, 0, 32'h0,   1, 1, 32'h00C, 0, 32'h0);
    vecs[10] = mk(0, 0, 0, 32'h0,   1, 1, 32'h010, 1, 32'h00C);
    vecs[11] = mk(0, 0, 1, 32'h100, 1, 1, 32'h010, 0, 32'h0);
    vecs[12] = mk(0, 0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0);
    vecs[13] = mk(0, 0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0);
    vecs[14] = mk(1, 1, 0, 32'h0,   1, 1, 32'h104, 1, 32'h100);
    vecs[15] = mk(0, 0, 0, 32'h0,   1, 1, 32'h104, 0, 32'h0);
    vecs[16] = mk(0, 0, 0, 32'h0,   1, 1, 32'h108, 1, 32'h104);
    vecs[17] = mk(0, 0, 1, 32'h203, 3, 1, 32'h108, 0, 32'h0);
    vecs[18] = mk(0, 0, 0, 32'h0,   3, 1, 32'h108, 0, 32'h0);
    vecs[19] = mk(0, 0, 0, 32'h0,   3, 1, 32'h108, 0, 32'h0);
    vecs[20] = mk(0, 0, 0, 32'h0,   3, 1, 32'h200, 0, 32'h0);
    vecs[21] = mk(0, 0, 0, 32'h0,   3, 1, 32'h200, 0, 32'h0);
    vecs[22] = mk(0, 0, 0, 32'h0,   3, 1, 32'h200, 0, 32'h0);
    vecs[23] = mk(0, 0, 0, 32'h0,   3, 1, 32'h200, 0, 32'h0);
    vecs[24] = mk(0, 0, 0, 32'h0,   3, 1, 32'h204, 1, 32'h200);

    repeat (3) tick();
    check_cleared("reset");
    release_reset();

    for (int i = 0; i < NV; i++) begin
      lat = vecs[i].lat;
      drive_ack();
      stall = vecs[i].s; flush = vecs[i].f; redirect = vecs[i].r; redirect_pc = vecs[i].rpc;
      check($sformatf("v%0d req", i), {31'b0, fs_o_imem_req}, {31'b0, vecs[i].e_req});
      check($sformatf("v%0d addr", i), fs_o_imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d ce", i), {31'b0, fs_o_ce}, {31'b0, vecs[i].e_ce});
      if (vecs[i].e_ce) begin
        check($sformatf("v%0d pc", i), fs_o_pc, vecs[i].e_pc);
        check($sformatf("v%0d instr", i), fs_o_instr, mem_word(vecs[i].e_pc));
        check($sformatf("v%0d pc4", i), fs_o_pc_plus4, vecs[i].e_pc + 32'd4);
      end
      tick();
    end
    stall = 1'b0; flush = 1'b0; redirect = 1'b0;

    // Unaligned redirect near the top of the address space, then wrap.
    lat = 1; drive_ack();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    check("wrap addr", fs_o_imem_addr, 32'hFFFF_FFFC);
    n = 0;
    while (!fs_o_ce && n < 10) begin tick(); n++; end
    check("wrap ce", {31'b0, fs_o_ce}, 32'd1);
    check("wrap pc", fs_o_pc, 32'hFFFF_FFFC);
    check("wrap pc4", fs_o_pc_plus4, 32'h0);
    check("wrap instr", fs_o_instr, mem_word(32'hFFFF_FFFC));
    check("wrap next addr", fs_o_imem_addr, 32'h0);

    // Reset while a slow request is outstanding; a late ack during reset is ignored.
    tick();
    tick();
    stall = 1'b1; lat = 3; drive_ack();
    tick();
    check("mr pre ce", {31'b0, fs_o_ce}, 32'd1);
    check("mr pre addr", fs_o_imem_addr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check_cleared("mid-req reset");
    ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    tick();
    tick();
    stall = 1'b0; lat = 1;
    release_reset();
    check("mr rel req", {31'b0, fs_o_imem_req}, 32'd1);
    check("mr rel addr", fs_o_imem_addr, 32'h0);
    check("mr rel ce", {31'b0, fs_o_ce}, 32'd0);
    tick();
    check("mr late ack ce", {31'b0, fs_o_ce}, 32'd0);

    // Drive into the hold state, then reset there.
    n = 0;
    while (!fs_o_ce && n < 10) begin tick(); n++; end
    stall = 1'b1;
    n = 0;
    while (fs_o_imem_req && n < 10) begin tick(); n++; end
    check("hold req", {31'b0, fs_o_imem_req}, 32'd0);
    check("hold addr", fs_o_imem_addr, 32'h8);
    check("hold ce", {31'b0, fs_o_ce}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_cleared("hold reset");
    tick();
    tick();
    stall = 1'b0; rnd_lat = 1'b1;
    release_reset();
    check("hr rel addr", fs_o_imem_addr, 32'h0);

    // Random stalls, latencies and redirects against an in-order stream model.
    exp_pc = 32'h0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      if (prev_req && !prev_ack) begin
        check("rnd req held", {31'b0, fs_o_imem_req}, 32'd1);
        check("rnd addr held", fs_o_imem_addr, prev_addr);
      end
      check("rnd addr align", fs_o_imem_addr & 32'h3, 32'h0);
      if (fs_o_ce && !stall) begin
        check("rnd pc", fs_o_pc, exp_pc);
        check("rnd instr", fs_o_instr, mem_word(exp_pc));
        check("rnd pc4", fs_o_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      tick();
    end
    check("rnd progress", {31'b0, consumed >= 100}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
